// File: rtl/mms_pkg.sv
// Shared MatrixMonSTARS definitions: pushbutton count and the key codes the
// calculator core expects for button indices 0-9.
package mms_pkg;

  localparam int unsigned NUM_PB_DEF = 10;

  typedef logic [3:0] key_code_t;

  // Indices 0-9 map straight onto the calculator's operand/operator key codes
  localparam key_code_t KEY_0 = 4'd0;
  localparam key_code_t KEY_1 = 4'd1;
  localparam key_code_t KEY_2 = 4'd2;
  localparam key_code_t KEY_3 = 4'd3;
  localparam key_code_t KEY_4 = 4'd4;
  localparam key_code_t KEY_5 = 4'd5;
  localparam key_code_t KEY_6 = 4'd6;
  localparam key_code_t KEY_7 = 4'd7;
  localparam key_code_t KEY_8 = 4'd8;
  localparam key_code_t KEY_9 = 4'd9;

endpackage

// File: rtl/pb_debounce_ch.sv
// One pushbutton channel: 2-flop synchroniser, stability counter, clean level
// and a registered one-cycle press pulse.
module pb_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic pb_raw,
  output logic pb_clean,
  output logic pb_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_clean;
  logic             r_clean_d;
  logic             r_pulse;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_clean_nxt;
  logic             w_pulse_nxt;

  // Any sample matching the clean level restarts the stability count
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    w_pulse_nxt = r_clean & ~r_clean_d;
    if (r_sync2 == r_clean) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_nxt   = '0;
      w_clean_nxt = ~r_clean;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync1   <= pb_raw;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_clean   <= w_clean_nxt;
      r_clean_d <= r_clean;
      r_pulse   <= w_pulse_nxt;
    end
  end

  assign pb_clean = r_clean;
  assign pb_pulse = r_pulse;

endmodule

// File: rtl/pb_debounce_encoder.sv
// Pushbutton front end: per-channel debounce plus a registered priority
// encoder that reports the lowest pressed index and a multi-press flag.
module pb_debounce_encoder
  import mms_pkg::*;
#(
  parameter int unsigned NUM_PB          = NUM_PB_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_clean,
  output logic [NUM_PB-1:0] pb_pulse,
  output logic              key_valid,
  output key_code_t         key_code,
  output logic              key_multi
);

  logic [NUM_PB-1:0] w_clean;
  logic [NUM_PB-1:0] w_pulse;
  key_code_t         w_code;
  logic [4:0]        w_pop;

  key_code_t         r_key_code;
  logic              r_key_valid;
  logic              r_key_multi;

  for (genvar g = 0; g < NUM_PB; g++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk      (clk),
      .n_rst    (n_rst),
      .pb_raw   (pb_raw[g]),
      .pb_clean (w_clean[g]),
      .pb_pulse (w_pulse[g])
    );
  end

  // Descending scan so the lowest set index wins
  always_comb begin
    w_code = '0;
    w_pop  = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (w_pulse[i]) w_code = 4'(i);
    end
    for (int i = 0; i < NUM_PB; i++) begin
      w_pop = w_pop + 5'(w_pulse[i]);
    end
  end

  // key_code is sticky between strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_multi <= 1'b0;
    end else begin
      r_key_valid <= |w_pulse;
      r_key_multi <= (w_pop > 5'd1);
      if (|w_pulse) r_key_code <= w_code;
    end
  end

  assign pb_clean  = w_clean;
  assign pb_pulse  = w_pulse;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_multi = r_key_multi;

endmodule

// File: tb/tb_pb_debounce_encoder.sv
// Directed bench for pb_debounce_encoder (DEBOUNCE_CYCLES=4) plus a random
// run of a DEBOUNCE_CYCLES=2 instance against a run-length reference model.
module tb_pb_debounce_encoder;

  logic       clk;
  logic       n_rst;
  logic [9:0] pb_raw;
  logic [9:0] pb_clean;
  logic [9:0] pb_pulse;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_multi;

  logic [9:0] pb_raw2;
  logic [9:0] pb_clean2;
  logic [9:0] pb_pulse2;
  logic       key_valid2;
  logic [3:0] key_code2;
  logic       key_multi2;

  int checks;
  int errors;

  pb_debounce_encoder #(.NUM_PB(10), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .n_rst(n_rst), .pb_raw(pb_raw), .pb_clean(pb_clean),
    .pb_pulse(pb_pulse), .key_valid(key_valid), .key_code(key_code),
    .key_multi(key_multi)
  );

  pb_debounce_encoder #(.NUM_PB(10), .DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .pb_raw(pb_raw2), .pb_clean(pb_clean2),
    .pb_pulse(pb_pulse2), .key_valid(key_valid2), .key_code(key_code2),
    .key_multi(key_multi2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_rst   = 1'b0;
    pb_raw  = '0;
    pb_raw2 = '0;
    #3;
    checks++;
    if (pb_clean !== 10'h000 || pb_pulse !== 10'h000) begin
      errors++;
      $display("FAIL reset_vec clean=%h pulse=%h expected 000/000", pb_clean, pb_pulse);
    end
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'd0 || key_multi !== 1'b0) begin
      errors++;
      $display("FAIL reset_key valid=%b code=%0d multi=%b expected 0/0/0", key_valid, key_code, key_multi);
    end
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic release_all();
    pb_raw = '0;
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_clean_press();
    int early_bad;
    int late_bad;
    early_bad = 0;
    late_bad  = 0;
    pb_raw[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k < 5 && pb_clean[3] !== 1'b0) early_bad++;
      if (k > 6 && pb_pulse !== 10'h000) late_bad++;
      if (k == 5) begin
        checks++;
        if (pb_clean[3] !== 1'b1 || pb_pulse !== 10'h000) begin
          errors++;
          $display("FAIL press_clean_edge clean3=%b pulse=%h expected 1/000", pb_clean[3], pb_pulse);
        end
      end
      if (k == 6) begin
        checks++;
        if (pb_pulse !== 10'h008 || key_valid !== 1'b0) begin
          errors++;
          $display("FAIL press_pulse pulse=%h valid=%b expected 008/0", pb_pulse, key_valid);
        end
      end
      if (k == 7) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd3 || key_multi !== 1'b0) begin
          errors++;
          $display("FAIL press_key valid=%b code=%0d multi=%b expected 1/3/0", key_valid, key_code, key_multi);
        end
      end
      if (k == 8) begin
        checks++;
        if (key_valid !== 1'b0 || key_code !== 4'd3) begin
          errors++;
          $display("FAIL press_key_hold valid=%b code=%0d expected 0/3", key_valid, key_code);
        end
      end
    end
    checks++;
    if (early_bad != 0) begin
      errors++;
      $display("FAIL press_early_clean count=%0d expected 0", early_bad);
    end
    checks++;
    if (late_bad != 0) begin
      errors++;
      $display("FAIL press_no_repeat extra_pulse_cycles=%0d expected 0", late_bad);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] seq;
    int first_rise;
    int pulses;
    int valids;
    seq        = 6'b101101;
    first_rise = -1;
    pulses     = 0;
    valids     = 0;
    for (int k = 0; k < 20; k++) begin
      pb_raw[0] = (k < 6) ? seq[5 - k] : 1'b1;
      tick();
      if (pb_clean[0] === 1'b1 && first_rise < 0) first_rise = k;
      if (pb_pulse[0] === 1'b1) pulses++;
      if (key_valid === 1'b1) valids++;
    end
    checks++;
    if (first_rise != 10) begin
      errors++;
      $display("FAIL bounce_rise_edge got=%0d expected 10", first_rise);
    end
    checks++;
    if (pulses != 1 || valids != 1) begin
      errors++;
      $display("FAIL bounce_pulse_count pulses=%0d valids=%0d expected 1/1", pulses, valids);
    end
    checks++;
    if (key_code !== 4'd0) begin
      errors++;
      $display("FAIL bounce_key_code got=%0d expected 0", key_code);
    end
  endtask

  task automatic test_release();
    int first_fall;
    int pulses;
    int valids;
    first_fall = -1;
    pulses     = 0;
    valids     = 0;
    pb_raw[5] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (pb_clean !== 10'h029) begin
      errors++;
      $display("FAIL release_setup clean=%h expected 029", pb_clean);
    end
    pb_raw[5] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pb_clean[5] === 1'b0 && first_fall < 0) first_fall = k;
      if (pb_pulse !== 10'h000) pulses++;
      if (key_valid === 1'b1) valids++;
    end
    checks++;
    if (first_fall != 5) begin
      errors++;
      $display("FAIL release_fall_edge got=%0d expected 5", first_fall);
    end
    checks++;
    if (pulses != 0 || valids != 0) begin
      errors++;
      $display("FAIL release_no_pulse pulses=%0d valids=%0d expected 0/0", pulses, valids);
    end
  endtask

  task automatic test_simultaneous();
    release_all();
    pb_raw[7] = 1'b1;
    pb_raw[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 6) begin
        checks++;
        if (pb_pulse !== 10'h084) begin
          errors++;
          $display("FAIL simul_pulse got=%h expected 084", pb_pulse);
        end
      end
      if (k == 7) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd2 || key_multi !== 1'b1) begin
          errors++;
          $display("FAIL simul_key valid=%b code=%0d multi=%b expected 1/2/1", key_valid, key_code, key_multi);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int first_rise;
    int pulses9;
    first_rise = -1;
    pulses9    = 0;
    release_all();
    pb_raw[4] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (pb_clean !== 10'h010 || key_code !== 4'd4) begin
      errors++;
      $display("FAIL rstmid_setup clean=%h code=%0d expected 010/4", pb_clean, key_code);
    end
    pb_raw[9] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    n_rst = 1'b0;
    #2;
    checks++;
    if (pb_clean !== 10'h000 || pb_pulse !== 10'h000 || key_code !== 4'd0 ||
        key_valid !== 1'b0 || key_multi !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async clean=%h pulse=%h code=%0d valid=%b multi=%b expected all 0",
               pb_clean, pb_pulse, key_code, key_valid, key_multi);
    end
    tick();
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (pb_clean[9] === 1'b1 && first_rise < 0) first_rise = k;
      if (pb_pulse[9] === 1'b1) pulses9++;
      if (k == 7) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd4 || key_multi !== 1'b1) begin
          errors++;
          $display("FAIL rstmid_key valid=%b code=%0d multi=%b expected 1/4/1", key_valid, key_code, key_multi);
        end
      end
    end
    checks++;
    if (first_rise != 5 || pulses9 != 1) begin
      errors++;
      $display("FAIL rstmid_rise edge=%0d pulses=%0d expected 5/1", first_rise, pulses9);
    end
  endtask

  task automatic test_saturation();
    logic [9:0] m_s1, m_s2, m_clean, m_clean_d, m_pulse, raw;
    int         m_run [10];
    int         prints;
    m_s1 = '0; m_s2 = '0; m_clean = '0; m_clean_d = '0; m_pulse = '0;
    prints = 0;
    for (int c = 0; c < 10; c++) m_run[c] = 0;
    for (int k = 0; k < 10000; k++) begin
      raw     = 10'($urandom);
      pb_raw2 = raw;
      tick();
      m_pulse   = m_clean & ~m_clean_d;
      m_clean_d = m_clean;
      for (int c = 0; c < 10; c++) begin
        if (m_s2[c] != m_clean[c]) begin
          m_run[c] = m_run[c] + 1;
          if (m_run[c] == 2) begin
            m_clean[c] = ~m_clean[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      checks++;
      if (pb_clean2 !== m_clean || pb_pulse2 !== m_pulse ||
          dut2.g_ch[0].u_ch.r_cnt > 2'd1) begin
        errors++;
        if (prints < 10) begin
          prints++;
          $display("FAIL sat_model cyc=%0d clean=%h pulse=%h cnt0=%0d expected %h/%h/<=1",
                   k, pb_clean2, pb_pulse2, dut2.g_ch[0].u_ch.r_cnt, m_clean, m_pulse);
        end
      end
    end
    pb_raw2 = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
